// File: rtl/bullcow_display.sv
// bullcow_display: renders bull/cow game state on an 8-digit multiplexed 7-segment display.
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   mode[2:0]           game state (000/001 setup, 010/011 guess, 111 end game)
//   result_valid        one-cycle strobe qualifying bulls/cows
//   bulls[2:0], cows[2:0] result of the current guess
//   winner              0 = J1, 1 = J2, captured on entry to end game
//   points_j1/j2[7:0]   win counts, captured (clamped to 99) on entry to end game
//   an[7:0]             active-low digit anodes, an[7] leftmost
//   seg[6:0]            active-low segments {g,f,e,d,c,b,a}
//   dp                  active-low decimal point, always off
module bullcow_display #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] mode,
    input  logic       result_valid,
    input  logic [2:0] bulls,
    input  logic [2:0] cows,
    input  logic       winner,
    input  logic [7:0] points_j1,
    input  logic [7:0] points_j2,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam int DW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [6:0] G_B     = 7'b0000011;
    localparam logic [6:0] G_C     = 7'b0100111;
    localparam logic [6:0] G_J     = 7'b1100001;
    localparam logic [6:0] G_S     = 7'b0010010;
    localparam logic [6:0] G_E     = 7'b0000110;
    localparam logic [6:0] G_T     = 7'b0000111;
    localparam logic [6:0] G_DASH  = 7'b0111111;
    localparam logic [6:0] G_BLANK = 7'b1111111;

    logic [DW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [BW-1:0] r_bcnt;
    logic          r_blink_on;
    logic [2:0]    r_mode;
    logic [2:0]    r_bulls;
    logic [2:0]    r_cows;
    logic          r_flag;
    logic          r_win;
    logic [6:0]    r_p1;
    logic [6:0]    r_p2;
    logic [7:0]    r_an;
    logic [6:0]    r_seg;

    logic       w_scan_end;
    logic       w_blink_end;
    logic       w_chg;
    logic       w_end;
    logic       w_enter;
    logic       w_setup;
    logic       w_guess;
    logic [6:0] w_p1;
    logic [6:0] w_p2;
    logic [6:0] w_bull_g;
    logic [6:0] w_cow_g;
    logic [6:0] w_d [8];

    function automatic logic [6:0] dig(input logic [3:0] v);
        case (v)
            4'd0:    dig = 7'b1000000;
            4'd1:    dig = 7'b1111001;
            4'd2:    dig = 7'b0100100;
            4'd3:    dig = 7'b0110000;
            4'd4:    dig = 7'b0011001;
            4'd5:    dig = 7'b0010010;
            4'd6:    dig = 7'b0000010;
            4'd7:    dig = 7'b1111000;
            4'd8:    dig = 7'b0000000;
            4'd9:    dig = 7'b0010000;
            default: dig = G_E;
        endcase
    endfunction

    // A count of 5..7 can only come from a faulty upstream; flag it with E.
    function automatic logic [6:0] count_glyph(input logic v, input logic [2:0] n);
        count_glyph = !v ? G_DASH : (n > 3'd4) ? G_E : dig({1'b0, n});
    endfunction

    assign w_scan_end  = (r_cnt == DW'(DIGIT_CYCLES - 1));
    assign w_blink_end = (r_bcnt == BW'(BLINK_CYCLES - 1));
    assign w_chg       = (mode != r_mode);
    assign w_end       = (mode == 3'b111);
    assign w_enter     = w_end && w_chg;
    assign w_setup     = (mode[2:1] == 2'b00);
    assign w_guess     = (mode[2:1] == 2'b01);
    assign w_p1        = (points_j1 > 8'd99) ? 7'd99 : points_j1[6:0];
    assign w_p2        = (points_j2 > 8'd99) ? 7'd99 : points_j2[6:0];
    assign w_bull_g    = count_glyph(r_flag, r_bulls);
    assign w_cow_g     = count_glyph(r_flag, r_cows);

    always_comb begin
        w_d[7] = (w_setup || w_guess || w_end) ? G_J : G_BLANK;
        w_d[6] = (w_setup || w_guess) ? dig({3'b000, mode[0]} + 4'd1) :
                 w_end ? dig({3'b000, r_win} + 4'd1) : G_BLANK;
        w_d[5] = G_BLANK;
        w_d[4] = w_guess ? w_bull_g : w_end ? dig(4'(r_p1 / 7'd10)) : G_BLANK;
        w_d[3] = w_guess ? G_B : w_end ? dig(4'(r_p1 % 7'd10)) : G_BLANK;
        w_d[2] = w_setup ? G_S : w_end ? G_DASH : G_BLANK;
        w_d[1] = w_setup ? G_E : w_guess ? w_cow_g : w_end ? dig(4'(r_p2 / 7'd10)) : G_BLANK;
        w_d[0] = w_setup ? G_T : w_guess ? G_C : w_end ? dig(4'(r_p2 % 7'd10)) : G_BLANK;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_bcnt     <= '0;
            r_blink_on <= 1'b1;
            r_mode     <= '0;
            r_bulls    <= '0;
            r_cows     <= '0;
            r_flag     <= 1'b0;
            r_win      <= 1'b0;
            r_p1       <= '0;
            r_p2       <= '0;
            r_an       <= 8'hFF;
            r_seg      <= 7'h7F;
        end else begin
            r_mode <= mode;
            r_cnt  <= w_scan_end ? '0 : r_cnt + 1'b1;
            if (w_scan_end)
                r_idx <= r_idx + 3'd1;
            // Capture takes priority over the mode-change clear.
            if (result_valid) begin
                r_bulls <= bulls;
                r_cows  <= cows;
                r_flag  <= 1'b1;
            end else if (w_chg) begin
                r_flag <= 1'b0;
            end
            if (w_enter) begin
                r_win <= winner;
                r_p1  <= w_p1;
                r_p2  <= w_p2;
            end
            if (!w_end || w_enter) begin
                r_bcnt     <= '0;
                r_blink_on <= 1'b1;
            end else if (w_blink_end) begin
                r_bcnt     <= '0;
                r_blink_on <= ~r_blink_on;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end
            // Blank all anodes for the first cycle of each slot to hide ghosting.
            r_an  <= (r_cnt == '0 || !r_blink_on) ? 8'hFF : ~(8'd1 << r_idx);
            r_seg <= w_d[r_idx];
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = 1'b1;
endmodule

// File: tb/tb_bullcow_display.sv
module tb_bullcow_display;
    localparam logic [6:0] J = 7'b1100001, S = 7'b0010010, E = 7'b0000110, T = 7'b0000111;
    localparam logic [6:0] B = 7'b0000011, C = 7'b0100111, DS = 7'b0111111, BL = 7'b1111111;
    localparam logic [6:0] N0 = 7'b1000000, N1 = 7'b1111001, N2 = 7'b0100100;
    localparam logic [6:0] N4 = 7'b0011001, N7 = 7'b1111000, N9 = 7'b0010000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] mode = 3'd0;
    logic       result_valid = 1'b0;
    logic [2:0] bulls = 3'd0;
    logic [2:0] cows = 3'd0;
    logic       winner = 1'b0;
    logic [7:0] points_j1 = 8'd0;
    logic [7:0] points_j2 = 8'd0;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    int   errors = 0;
    int   checks = 0;
    logic len_en = 1'b0;
    logic [14:0] sb [$];

    bullcow_display #(.DIGIT_CYCLES(4), .BLINK_CYCLES(16)) dut (
        .clock(clock), .reset(reset), .mode(mode), .result_valid(result_valid),
        .bulls(bulls), .cows(cows), .winner(winner), .points_j1(points_j1),
        .points_j2(points_j2), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [6:0] s);
        sb.push_back({a, s});
    endtask

    task automatic wait_slot(input logic [7:0] a);
        logic [7:0] p;
        bit ok;
        p = an;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            if (an == a && p != a) ok = 1;
            p = an;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL sync: slot an=%h never started", a);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected slots never shown", sb.size());
            sb.delete();
        end
    endtask

    // f lists d7..d0; d0 is pushed first because the scan starts at index 0.
    task automatic check_frame(input logic [55:0] f);
        wait_slot(8'h7F);
        for (int i = 0; i < 8; i++) push(~(8'd1 << i), f[7*i +: 7]);
        drain();
    endtask

    // Monitor: each new visible slot pops one expected {an,seg}; also checks slot timing.
    initial begin
        logic [7:0]  prev_an;
        logic [14:0] e;
        int act_len;
        int ff_len;
        prev_an = 8'hFF;
        act_len = 0;
        ff_len  = 0;
        forever begin
            @(posedge clock);
            #1;
            if (an != 8'hFF) begin
                if (prev_an == 8'hFF || an != prev_an) begin
                    if (len_en && prev_an == 8'hFF) chk("ghost length", ff_len, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("slot {an,seg}", {an, seg}, e);
                    end
                    act_len = 1;
                end else begin
                    act_len++;
                end
                ff_len = 0;
            end else begin
                if (len_en && prev_an != 8'hFF) chk("active length", act_len, 3);
                ff_len++;
            end
            prev_an = an;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ff;
        repeat (3) @(negedge clock);
        chk("reset an", an, 8'hFF);
        chk("reset seg", seg, 7'h7F);
        chk("reset dp", dp, 1'b1);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("post-reset ghost", an, 8'hFF);
        @(posedge clock); #1;
        chk("post-reset an d0", an, 8'hFE);
        chk("post-reset seg d0", seg, T);
        @(negedge clock);
        len_en = 1'b1;
        check_frame({J, N1, BL, BL, BL, S, E, T});
        mode = 3'b010;
        check_frame({J, N1, BL, DS, B, BL, DS, C});
        @(negedge clock); result_valid = 1'b1; bulls = 3'd2; cows = 3'd1;
        @(negedge clock); result_valid = 1'b0;
        check_frame({J, N1, BL, N2, B, BL, N1, C});
        @(negedge clock); mode = 3'b011;
        check_frame({J, N2, BL, DS, B, BL, DS, C});
        @(negedge clock); mode = 3'b010;
        @(negedge clock); mode = 3'b011; result_valid = 1'b1; bulls = 3'd5; cows = 3'd4;
        @(negedge clock); result_valid = 1'b0;
        check_frame({J, N2, BL, E, B, BL, N4, C});
        @(negedge clock); mode = 3'b101;
        check_frame({BL, BL, BL, BL, BL, BL, BL, BL});
        points_j1 = 8'd7; points_j2 = 8'd150; winner = 1'b1;
        wait_slot(8'h7F);
        mode = 3'b111;
        len_en = 1'b0;
        push(8'hFE, N9); push(8'hFD, N9); push(8'hFB, DS); push(8'hF7, N7);
        drain();
        wait_slot(8'hF7);
        mode = 3'b000;
        @(negedge clock);
        mode = 3'b111;
        push(8'hEF, N0); push(8'hDF, BL); push(8'hBF, N2); push(8'h7F, J);
        @(negedge clock);
        ff = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (an == 8'hFF) ff++;
        end
        chk("blink visible half blanks", ff, 4);
        ff = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (an == 8'hFF) ff++;
        end
        chk("blink dark half blanks", ff, 16);
        drain();
        repeat (20) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("mid-blink reset an", an, 8'hFF);
        chk("mid-blink reset seg", seg, 7'h7F);
        chk("mid-blink reset dp", dp, 1'b1);
        mode = 3'b000;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("restart ghost", an, 8'hFF);
        @(posedge clock); #1;
        chk("restart an d0", an, 8'hFE);
        chk("restart seg d0", seg, T);
        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
